wb_cmd_master: RTL and testbench

Parametrised Wishbone classic master that drives the SoC IO bus from a queued command stream, replacing ad-hoc signal forcing with a proper bus agent. Commands (address, data, byte-select, direction) enter a DEPTH-entry FIFO, are issued one at a time as Wishbone cycles, and each completion is returned on a response port with read data and an error flag. It sits beside the core as a second master on the IO bus: a debug/test-access path usable from the UART or JTAG front ends and from the bench.

---
 rtl/wb_cmd_master.sv | 239 +++++++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Wishbone classic master fed from a queued command stream. Commands
//   (address, write data, byte selects, direction) are buffered in a
//   DEPTH-entry FIFO and issued one at a time as single Wishbone cycles.
//   Each completion is presented on a response port with read data and
//   an error flag, and is held there until the consumer takes it.
//
//   Optional feature macro: WB_CMD_TIMEOUT_EN
//     defined   : a 16-bit bus timer aborts a cycle after TIMEOUT clocks
//                 without ack/err, reporting rsp_err=1.
//     undefined : no timer; a cycle waits indefinitely for ack/err and the
//                 TIMEOUT parameter has no effect.
//
// Ports
//   clock, reset_n          : clock (rising edge), async active-low reset
//   cmd_valid/ready         : command handshake; ready = FIFO not full
//   cmd_we/adr/dat/sel      : command direction, address, data, selects
//   rsp_valid/ready         : response handshake
//   rsp_dat/we/err          : read data (0 for writes/errors), direction,
//                             error (wb_err_i or timeout)
//   wb_*_o                  : registered Wishbone request outputs
//   wb_dat_i/ack_i/err_i    : Wishbone slave response
//   busy                    : FSM active or commands queued
//   cmd_count               : FIFO occupancy
module wb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [ADDR_W-1:0]          cmd_adr,
    input  logic [DATA_W-1:0]          cmd_dat,
    input  logic [DATA_W/8-1:0]        cmd_sel,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_dat,
    output logic                       rsp_we,
    output logic                       rsp_err,
    output logic [ADDR_W-1:0]          wb_adr_o,
    output logic [DATA_W-1:0]          wb_dat_o,
    output logic [DATA_W/8-1:0]        wb_sel_o,
    output logic                       wb_we_o,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    input  logic [DATA_W-1:0]          wb_dat_i,
    input  logic                       wb_ack_i,
    input  logic                       wb_err_i,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] cmd_count
);

    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int CMD_W = 1 + ADDR_W + DATA_W + SEL_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Command storage: {we, adr, dat, sel}. Data only, never reset.
    logic [CMD_W-1:0] mem [DEPTH];
    logic [CMD_W-1:0] head;
    logic             push;
    logic             pop;

    state_t             state_q,     state_d;
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [ADDR_W-1:0]  wb_adr_q,    wb_adr_d;
    logic [DATA_W-1:0]  wb_dat_q,    wb_dat_d;
    logic [SEL_W-1:0]   wb_sel_q,    wb_sel_d;
    logic               wb_we_q,     wb_we_d;
    logic               wb_cyc_q,    wb_cyc_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_dat_q,   rsp_dat_d;
    logic               rsp_we_q,    rsp_we_d;
    logic               rsp_err_q,   rsp_err_d;

`ifdef WB_CMD_TIMEOUT_EN
    // Terminating when the pre-increment count equals TIMEOUT-1 keeps
    // cyc/stb high for exactly TIMEOUT clocks.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] timer_q, timer_d;
`else
    localparam logic [15:0] UNUSED_TIMEOUT = 16'(TIMEOUT);
`endif

    assign cmd_ready = (count_q != CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        wb_adr_d    = wb_adr_q;
        wb_dat_d    = wb_dat_q;
        wb_sel_d    = wb_sel_q;
        wb_we_d     = wb_we_q;
        wb_cyc_d    = wb_cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
`ifdef WB_CMD_TIMEOUT_EN
        timer_d     = timer_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    {wb_we_d, wb_adr_d, wb_dat_d, wb_sel_d} = head;
                    wb_cyc_d = 1'b1;
                    state_d  = S_BUS;
`ifdef WB_CMD_TIMEOUT_EN
                    timer_d  = '0;
`endif
                end
            end
            S_BUS: begin
                // Request registers are left untouched so the bus request
                // stays stable for the whole cycle.
                if (wb_err_i) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = wb_we_q;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = S_RESP;
                end else if (wb_ack_i) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = wb_we_q;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = wb_we_q ? '0 : wb_dat_i;
                    state_d     = S_RESP;
                end
`ifdef WB_CMD_TIMEOUT_EN
                else if (timer_q == TMO_LAST) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = wb_we_q;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = S_RESP;
                end else begin
                    timer_d     = timer_q + 16'd1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                wb_cyc_d = 1'b0;
            end
        endcase

        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wb_adr_q    <= '0;
            wb_dat_q    <= '0;
            wb_sel_q    <= '0;
            wb_we_q     <= 1'b0;
            wb_cyc_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef WB_CMD_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wb_adr_q    <= wb_adr_d;
            wb_dat_q    <= wb_dat_d;
            wb_sel_q    <= wb_sel_d;
            wb_we_q     <= wb_we_d;
            wb_cyc_q    <= wb_cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
`ifdef WB_CMD_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign wb_adr_o  = wb_adr_q;
    assign wb_dat_o  = wb_dat_q;
    assign wb_sel_o  = wb_sel_q;
    assign wb_we_o   = wb_we_q;
    assign wb_cyc_o  = wb_cyc_q;
    assign wb_stb_o  = wb_cyc_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign cmd_count = count_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_we = 1'b0;
    logic [ADDR_W-1:0] cmd_adr = '0;
    logic [DATA_W-1:0] cmd_dat = '0;
    logic [3:0]        cmd_sel = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_dat;
    logic              rsp_we;
    logic              rsp_err;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [3:0]        wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [DATA_W-1:0] wb_dat_i = '0;
    logic              wb_ack_i = 1'b0;
    logic              wb_err_i = 1'b0;
    logic              busy;
    logic [2:0]        cmd_count;

    int errors = 0;
    int checks = 0;

    wb_cmd_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_we   (rsp_we),
        .rsp_err  (rsp_err),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .busy     (busy),
        .cmd_count(cmd_count)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
        checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %0b/%0b want 0/0", wb_cyc_o, wb_stb_o); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0 || cmd_count !== 3'd0) begin errors++; $display("FAIL reset_busy_count: got %0b/%0d want 0/0", busy, cmd_count); end
        checks++; if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || rsp_dat !== 32'h0) begin errors++; $display("FAIL reset_data: adr %h dat %h rsp %h want 0", wb_adr_o, wb_dat_o, rsp_dat); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (wb_cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_idle: cyc %0b ready %0b want 0/1", wb_cyc_o, cmd_ready); end
    endtask

    // Read, slave inserts 3 wait states then acks with 0xDEADBEEF.
    task automatic test_read_wait();
        int high;
        push_cmd(1'b0, 32'h2000_0004, 32'h0, 4'hF);
        checks++; if (cmd_count !== 3'd1 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL read_e0: count %0d cyc %0b want 1/0", cmd_count, wb_cyc_o); end
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_adr_o !== 32'h2000_0004 || wb_we_o !== 1'b0) begin errors++; $display("FAIL read_issue: cyc %0b stb %0b adr %h we %0b want 1/1/20000004/0", wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o); end
        checks++; if (cmd_count !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL read_pop: count %0d busy %0b want 0/1", cmd_count, busy); end
        high = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb_cyc_o === 1'b1) high++;
        end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        if (wb_cyc_o === 1'b1) high++;
        checks++; if (high !== 4) begin errors++; $display("FAIL read_cyc_len: got %0d want 4", high); end
        checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || rsp_we !== 1'b0) begin errors++; $display("FAIL read_rsp: v %0b dat %h err %0b we %0b want 1/deadbeef/0/0", rsp_valid, rsp_dat, rsp_err, rsp_we); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rsp_hold: v %0b dat %h want 1/deadbeef", rsp_valid, rsp_dat); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_handshake: v %0b busy %0b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_write();
        push_cmd(1'b1, 32'h2000_0000, 32'h0000_0055, 4'h1);
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 || wb_sel_o !== 4'h1 || wb_dat_o !== 32'h55 || wb_adr_o !== 32'h2000_0000) begin errors++; $display("FAIL write_issue: cyc %0b we %0b sel %h dat %h adr %h", wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o); end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hFFFF_FFFF;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        checks++; if (wb_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || rsp_err !== 1'b0 || rsp_we !== 1'b1) begin errors++; $display("FAIL write_rsp: cyc %0b v %0b dat %h err %0b we %0b want 0/1/0/0/1", wb_cyc_o, rsp_valid, rsp_dat, rsp_err, rsp_we); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_handshake: v %0b want 0", rsp_valid); end
    endtask

    // DEPTH+1 pushes with the response stalled, then in-order drain.
    task automatic test_fifo_full();
        logic [31:0] adr;
        wb_ack_i = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got 0 want 1", i); end
            push_cmd(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF);
        end
        checks++; if (cmd_ready !== 1'b0 || cmd_count !== 3'(DEPTH)) begin errors++; $display("FAIL full_state: ready %0b count %0d want 0/%0d", cmd_ready, cmd_count, DEPTH); end
        checks++; if (rsp_valid !== 1'b1 || wb_adr_o !== 32'h100) begin errors++; $display("FAIL full_first: v %0b adr %h want 1/100", rsp_valid, wb_adr_o); end
        push_cmd(1'b0, 32'hBAD, 32'h0, 4'hF);
        checks++; if (cmd_count !== 3'(DEPTH)) begin errors++; $display("FAIL full_reject: count %0d want %0d", cmd_count, DEPTH); end
        for (int i = 1; i < DEPTH + 1; i++) begin
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            checks++; if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL drain_gap_%0d: v %0b cyc %0b want 0/0", i, rsp_valid, wb_cyc_o); end
            tick();
            adr = 32'h100 + 32'(4 * i);
            checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== adr || cmd_count !== 3'(DEPTH - i)) begin errors++; $display("FAIL drain_issue_%0d: cyc %0b adr %h count %0d want 1/%h/%0d", i, wb_cyc_o, wb_adr_o, cmd_count, adr, DEPTH - i); end
            if (i == 1) begin
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got 0 want 1"); end
            end
            tick();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL drain_rsp_%0d: v 0 want 1", i); end
        end
        wb_ack_i = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (busy !== 1'b0 || cmd_count !== 3'd0) begin errors++; $display("FAIL drain_done: busy %0b count %0d want 0/0", busy, cmd_count); end
    endtask

    task automatic test_timeout();
        int high;
        wb_dat_i = 32'h1234_5678;
        push_cmd(1'b0, 32'h300, 32'h0, 4'hF);
        tick();
        high = 1;
`ifdef WB_CMD_TIMEOUT_EN
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (wb_cyc_o !== 1'b1) break;
            high++;
        end
        checks++; if (high !== TIMEOUT) begin errors++; $display("FAIL timeout_len: got %0d want %0d", high, TIMEOUT); end
`else
        for (int i = 0; i < 999; i++) begin
            tick();
            if (wb_cyc_o === 1'b1) high++;
        end
        checks++; if (high !== 1000) begin errors++; $display("FAIL no_timeout_len: got %0d want 1000", high); end
        wb_err_i = 1'b1;
        tick();
        wb_err_i = 1'b0;
`endif
        wb_dat_i = 32'h0;
        checks++; if (wb_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0) begin errors++; $display("FAIL timeout_rsp: cyc %0b v %0b err %0b dat %h want 0/1/1/0", wb_cyc_o, rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_ack_err();
        push_cmd(1'b0, 32'h400, 32'h0, 4'hF);
        tick();
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'hCAFE_F00D;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0 || rsp_we !== 1'b0) begin errors++; $display("FAIL ack_err_rsp: v %0b err %0b dat %h we %0b want 1/1/0/0", rsp_valid, rsp_err, rsp_dat, rsp_we); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_cmd(1'b1, 32'h500, 32'h1, 4'hF);
        push_cmd(1'b1, 32'h504, 32'h2, 4'hF);
        push_cmd(1'b1, 32'h508, 32'h3, 4'hF);
        checks++; if (wb_cyc_o !== 1'b1 || cmd_count !== 3'd2) begin errors++; $display("FAIL mid_setup: cyc %0b count %0d want 1/2", wb_cyc_o, cmd_count); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL mid_cyc_drop: cyc %0b stb %0b want 0/0", wb_cyc_o, wb_stb_o); end
        checks++; if (cmd_count !== 3'd0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_state: count %0d v %0b ready %0b busy %0b want 0/0/1/0", cmd_count, rsp_valid, cmd_ready, busy); end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checks++; if (wb_cyc_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_discard: cyc %0b busy %0b want 0/0", wb_cyc_o, busy); end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_write();
        test_fifo_full();
        test_timeout();
        test_ack_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
